nibble_serial_adder_ctrl: RTL
=============================

Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that adds or subtracts WIDTH-bit operands through one shared 4-bit full-adder slice, one nibble per clock, from LSB to MSB.
- Sits between a requester using a valid/ready interface and the 4-bit adder datapath.
- Owns the operand shift registers, the carry flip-flop between nibbles, result assembly and the output handshake.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, derived value (localparam): number of nibble steps per operation.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  controller can accept a request.
- a  input  WIDTH  operand A, captured on acceptance.
- b  input  WIDTH  operand B, captured on acceptance.
- cin  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  selects the operation: 0 computes a+b+cin; 1 computes a-b.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH-1; for sub, 1 means no borrow.
- overflow  output  1  two's-complement signed overflow.
- busy  output  1  high while a request is being processed or a result is waiting to be taken.

Behaviour:
- Reset, asynchronous, takes effect immediately: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, busy=0. The internal carry, nibble counter and operand registers are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1 and busy=0.
  - A request is accepted when in_valid && in_ready on a rising edge.
  - On acceptance, capture a into A_reg.
  - Capture B_reg = sub ? ~b : b.
  - Load carry = sub ? 1 : cin.
  - Set the nibble counter to 0, then go to RUN.
- RUN:
  - in_ready=0 and busy=1.
  - Each cycle, the adder slice is fed A_reg[3:0], B_reg[3:0] and carry.
  - The 4-bit slice sum is shifted into the MSB nibble of the result register, so the result register shifts right by 4.
  - A_reg and B_reg shift right by 4, and carry takes the slice carry-out.
  - On the step with counter == NIB-1:
    - Compute overflow = (A_msb == B_msb) && (slice_sum_msb != A_msb). A_msb and B_msb are bit 3 of the current nibbles; B_msb is taken after the inversion applied for sub.
    - Latch cout from the slice carry-out.
    - Go to DONE.
  - Otherwise, increment the counter.
- DONE:
  - out_valid=1 and busy=1.
  - sum, cout and overflow are held stable while out_valid=1 and out_ready=0.
  - When out_valid && out_ready on a rising edge, go to IDLE and drop out_valid.
  - sum, cout and overflow keep their last values in IDLE.
- Timing:
  - Latency from the accepting edge to out_valid high is NIB+1 edges; for WIDTH=16, out_valid is high 5 cycles after acceptance.
  - Throughput is at most one operation per NIB+2 cycles.
  - There is no pipelining, and in_ready is never high in the same cycle as out_valid.
- Arithmetic:
  - All additions are modulo 2^WIDTH.
  - For sub, cout=1 iff a >= b as unsigned values.
- Boundary conditions:
  - While not in IDLE, in_valid is ignored and no operand is captured.
  - An out_ready pulse outside DONE has no effect.
  - Reset asserted during RUN or DONE aborts the operation. No out_valid is produced, and the controller returns to the reset state.
  - in_valid held high continuously means requests are accepted back-to-back, one per IDLE visit.
  - a, b, cin and sub may change freely after acceptance without affecting the result.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0FFF, cin=0, sub=0 -> after 5 cycles out_valid=1, sum=0x2233, cout=0, overflow=0.
- a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, overflow=0. Repeat with a=0xFFFE, b=0x0000, cin=1 -> sum=0xFFFF, cout=0.
- a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, overflow=0. a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, overflow=1.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, overflow=1. Hold out_ready=0 for 10 cycles -> out_valid, sum and overflow stay stable and in_ready stays 0. Then pulse out_ready -> in_ready=1 the next cycle.
- Assert rst in the 2nd RUN cycle of a=0x1111, b=0x2222 -> out_valid never rises, and the reset values appear immediately. Then a new request a=0x0001, b=0x0002 -> sum=0x0003.
- Hold in_valid=1 with a new operand set each acceptance, out_ready=1 -> three operations complete with correct sums. Acceptances are NIB+2=6 cycles apart, and no request is captured while busy=1.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - nibble-serial add/subtract sequencer around one 4-bit adder slice
//
// Purpose:
//   Accepts a WIDTH-bit add or subtract request over a valid/ready handshake.
//   The operation runs through a single 4-bit full-adder slice, one nibble per
//   clock, LSB nibble first. The carry ripples between nibbles through a flop.
//   The result is presented on a valid/ready output handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   request present
//   in_ready   controller can accept a request (IDLE only)
//   a, b       WIDTH-bit operands, captured on acceptance
//   cin        carry-in for add; ignored for subtract
//   sub        0: a+b+cin, 1: a-b
//   out_valid  result available (DONE only)
//   out_ready  consumer takes the result
//   sum        WIDTH-bit result
//   cout       carry out of bit WIDTH-1 (for subtract, 1 = no borrow)
//   overflow   two's-complement signed overflow
//   busy       operation in progress or result waiting

module nibble_serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             busy
);

   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
   logic             carry_q, cout_q, ovf_q;
   logic [CW-1:0]    cnt_q;

   logic [4:0]       slice;
   logic             last_step;
   logic             accept;

   // The shared 4-bit adder slice; bit 4 is the slice carry-out.
   assign slice     = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};
   assign last_step = (cnt_q == CW'(NIB - 1));
   assign accept    = in_valid && in_ready;

   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last_step) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath. The visible result (sum_q) is only updated on the final step, so
   // the partial result shifting through res_q never shows on the outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q     <= a;
                  // Subtract as a + ~b + 1.
                  b_q     <= sub ? ~b : b;
                  carry_q <= sub ? 1'b1 : cin;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               a_q     <= {4'b0000, a_q[WIDTH-1:4]};
               b_q     <= {4'b0000, b_q[WIDTH-1:4]};
               res_q   <= {slice[3:0], res_q[WIDTH-1:4]};
               carry_q <= slice[4];
               if (last_step) begin
                  sum_q  <= {slice[3:0], res_q[WIDTH-1:4]};
                  cout_q <= slice[4];
                  // Same-sign operands yielding a different-sign result.
                  ovf_q  <= (a_q[3] == b_q[3]) && (slice[3] != a_q[3]);
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
